// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of the data-side memory port between two
// requesters. Sub-word stores become read-modify-write because the memory
// only accepts full-word writes.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_be,
    output logic        m0_gnt,
    output logic        m0_done,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_be,
    output logic        m1_gnt,
    output logic        m1_done,
    output logic [31:0] m1_rdata,
    output logic [31:0] mem_ra,
    input  logic [31:0] mem_rd,
    output logic        mem_we,
    output logic [31:0] mem_wa,
    output logic [31:0] mem_wd
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WRITE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_last;      // owner of the most recent grant (0 = m0, 1 = m1)
    logic        r_owner;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_merged;
    logic [31:0] r_m0_rdata;
    logic [31:0] r_m1_rdata;
    logic        r_m0_done;
    logic        r_m1_done;

    logic        w_idle;
    logic        w_m0_gnt;
    logic        w_m1_gnt;
    logic        w_accept;
    logic        w_partial;
    logic        w_finish;
    logic        w_mem_we;
    logic [31:0] w_merged;

    // Grants only in IDLE; the loser of the last grant wins a tie. Gating with
    // rst_n keeps both grants low for the whole reset.
    assign w_idle    = (r_state == S_IDLE);
    assign w_m0_gnt  = rst_n & w_idle & m0_req & (~m1_req | r_last);
    assign w_m1_gnt  = rst_n & w_idle & m1_req & (~m0_req | ~r_last);
    assign w_accept  = w_m0_gnt | w_m1_gnt;

    // A write needs a second cycle only when some, but not all, lanes are enabled.
    assign w_partial = r_we & (r_be != 4'h0) & (r_be != 4'hF);
    assign w_finish  = ((r_state == S_ACCESS) & ~w_partial) | (r_state == S_WRITE);

    // Lane merge: enabled lanes from the store data, the rest from memory.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_merged[8*gi +: 8] = r_be[gi] ? r_wdata[8*gi +: 8] : mem_rd[8*gi +: 8];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and memory write-enable decode.
    always_comb begin
        w_state_next = r_state;
        w_mem_we     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_mem_we     = r_we & (r_be == 4'hF);
                w_state_next = w_partial ? S_WRITE : S_IDLE;
            end
            S_WRITE: begin
                w_mem_we     = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Capture the accepted request and build the merged word for partial stores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last   <= 1'b1;
            r_owner  <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_be     <= 4'h0;
            r_merged <= 32'h0;
        end else begin
            if (w_accept) begin
                r_owner <= w_m1_gnt;
                r_last  <= w_m1_gnt;
                r_we    <= w_m1_gnt ? m1_we    : m0_we;
                r_addr  <= w_m1_gnt ? m1_addr  : m0_addr;
                r_wdata <= w_m1_gnt ? m1_wdata : m0_wdata;
                r_be    <= w_m1_gnt ? m1_be    : m0_be;
            end
            if ((r_state == S_ACCESS) && w_partial) begin
                r_merged <= w_merged;
            end
        end
    end

    // Completion pulses and per-requester read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m0_done  <= 1'b0;
            r_m1_done  <= 1'b0;
            r_m0_rdata <= 32'h0;
            r_m1_rdata <= 32'h0;
        end else begin
            r_m0_done <= w_finish & ~r_owner;
            r_m1_done <= w_finish & r_owner;
            if ((r_state == S_ACCESS) && !r_we) begin
                if (r_owner) begin
                    r_m1_rdata <= mem_rd;
                end else begin
                    r_m0_rdata <= mem_rd;
                end
            end
        end
    end

    assign m0_gnt   = w_m0_gnt;
    assign m1_gnt   = w_m1_gnt;
    assign m0_done  = r_m0_done;
    assign m1_done  = r_m1_done;
    assign m0_rdata = r_m0_rdata;
    assign m1_rdata = r_m1_rdata;
    assign mem_ra   = r_addr;
    assign mem_wa   = r_addr;
    assign mem_we   = w_mem_we;
    assign mem_wd   = (r_state == S_WRITE) ? r_merged : r_wdata;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the data-side port of the unified word memory (read port 2 plus the single write port) between two requesters: m0 (CPU load/store unit) and m1 (program loader / debug master).
- Round-robin arbitration with a req/gnt accept handshake and a one-cycle done pulse per operation.
- Implements byte-enable stores as read-modify-write, because the memory only writes full words.
- Instruction fetch on memory read port 1 does not pass through this block.

Parameters:
- none

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- m0_req  in  1  requester 0 has an operation pending
- m0_we  in  1  1 = write, 0 = read
- m0_addr  in  32  byte address; bits [1:0] ignored
- m0_wdata  in  32  write data, byte-lane aligned
- m0_be  in  4  byte enables; writes only
- m0_gnt  out  1  operation accepted this cycle
- m0_done  out  1  one-cycle completion pulse
- m0_rdata  out  32  read data, valid while m0_done=1
- m1_req, m1_we, m1_addr, m1_wdata, m1_be, m1_gnt, m1_done, m1_rdata  same widths and meanings for requester 1
- mem_ra  out  32  drives memory read address 2
- mem_rd  in  32  memory read data 2 (combinational from mem_ra)
- mem_we  out  1  memory write enable
- mem_wa  out  32  memory write address
- mem_wd  out  32  memory write data

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE and the round-robin pointer to last=1, so m0 has priority.
  - All gnt, done and mem_we outputs go to 0 immediately.
  - rdata, mem_ra, mem_wa and mem_wd go to 0.
  - Any in-flight operation is dropped. A partial write caught in the WRITE state is never committed.
- States: IDLE, ACCESS, WRITE.
- Grants:
  - Issued only in IDLE and computed combinationally.
  - m0_gnt = idle & m0_req & (!m1_req | last==1).
  - m1_gnt = idle & m1_req & (!m0_req | last==0).
  - At most one gnt is high in any cycle.
- Accept: on a clock edge with req&gnt, capture we, addr, wdata, be and the owner id. Set last=owner and go to ACCESS. Requesters hold req and their fields stable until gnt.
- ACCESS (one cycle):
  - mem_ra = addr_q and mem_wa = addr_q.
  - Read: at the edge, rdata_q <= mem_rd; go to IDLE with the owner's done=1 for the next cycle.
  - Write with be=4'hF: mem_we=1 and mem_wd=wdata_q this cycle; go to IDLE with done=1.
  - Write with be=4'h0: no memory write; go to IDLE with done=1.
  - Write with any other be: capture the merged word per lane i: be[i] ? wdata_q[8i+7:8i] : mem_rd[8i+7:8i]. Go to WRITE.
- WRITE (one cycle): mem_we=1, mem_wa=addr_q, mem_wd=merged word; go to IDLE with done=1.
- Latency from accept edge to done: 2 cycles for reads and full or empty writes, 3 cycles for partial writes.
- done and rdata:
  - done is high exactly one cycle, in IDLE.
  - A new grant may be issued in the same cycle as done, so back-to-back throughput is one op per 2 cycles.
  - mX_rdata holds the last read value for that requester; it is undefined for writes but must not be X after reset.
- mem_we is 0 in every state and case other than those above.
- Addresses beyond memory size: the memory returns 0 on read and drops the write. The arbiter still completes normally with done.
- Fairness: under continuous requests from both, grants strictly alternate. A single requester is never starved beyond one competing operation.

Test Plan:
- Reset, then m0 reads addr 0x10 holding 0xDEADBEEF → m0_gnt in cycle 0, m0_done and m0_rdata=0xDEADBEEF in cycle 2; m1 outputs stay 0.
- m1 writes 0x12345678, be=F, to 0x20, then m0 reads 0x20 → mem_we=1 for exactly one cycle with mem_wa=0x20; read returns 0x12345678.
- Word 0x30 = 0xAABBCCDD; m0 writes wdata=0x00001100, be=4'b0010 → ACCESS has mem_we=0, WRITE has mem_we=1 with mem_wd=0xAABB11DD; done on cycle 3.
- m0_req and m1_req held high for 4 operations each → grant order m0, m1, m0, m1, …; each done goes to the matching requester.
- Assert rst_n=0 in the WRITE state of a partial write → mem_we drops to 0 without a clock edge; memory word unchanged; after release, m0 wins a simultaneous request.
- Write with be=0 to 0x40 → no mem_we pulse; done after 2 cycles.
